// File: rtl/pwm_5_variation.sv
// ============================================================================
//  Module   : pwm_5_variation
//  Purpose  : Single-channel PWM with five duty levels stepped by
//             synchronized increase/decrease presses; glitch-free updates.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_5_variation #(
  parameter int unsigned PERIOD      = 10,
  parameter int unsigned HIGH0       = 1,
  parameter int unsigned HIGH1       = 3,
  parameter int unsigned HIGH2       = 5,
  parameter int unsigned HIGH3       = 7,
  parameter int unsigned HIGH4       = 9,
  parameter int unsigned RESET_LEVEL = 2
) (
  input  wire  clk,
  output logic out,
  input  wire  increase,
  input  wire  decrease,
  input  wire  rst
);

  localparam int unsigned c_CNT_W = $clog2(PERIOD);
  // High time can equal PERIOD, so it may need one more bit than the counter.
  localparam int unsigned c_AH_W  = $clog2(PERIOD + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(PERIOD - 1);

  function automatic logic [c_AH_W-1:0] high_of(input logic [2:0] lvl);
    case (lvl)
      3'd0:    high_of = c_AH_W'(HIGH0);
      3'd1:    high_of = c_AH_W'(HIGH1);
      3'd2:    high_of = c_AH_W'(HIGH2);
      3'd3:    high_of = c_AH_W'(HIGH3);
      default: high_of = c_AH_W'(HIGH4);
    endcase
  endfunction

  logic               inc_s1_q, inc_s2_q, inc_p_q;
  logic               dec_s1_q, dec_s2_q, dec_p_q;
  logic [2:0]         level_q, level_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic [c_AH_W-1:0]  active_high_q;
  logic               out_q;
  logic               w_inc_pulse, w_dec_pulse, w_wrap;

  assign w_inc_pulse = inc_s2_q & ~inc_p_q;
  assign w_dec_pulse = dec_s2_q & ~dec_p_q;
  assign w_wrap      = (cnt_q == c_LAST);
  assign cnt_d       = w_wrap ? '0 : cnt_q + 1'b1;

  // Simultaneous presses cancel; both directions saturate.
  always_comb begin
    level_d = level_q;
    if (w_inc_pulse && !w_dec_pulse && level_q != 3'd4) begin
      level_d = level_q + 3'd1;
    end else if (w_dec_pulse && !w_inc_pulse && level_q != 3'd0) begin
      level_d = level_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inc_s1_q      <= 1'b0;
      inc_s2_q      <= 1'b0;
      inc_p_q       <= 1'b0;
      dec_s1_q      <= 1'b0;
      dec_s2_q      <= 1'b0;
      dec_p_q       <= 1'b0;
      level_q       <= 3'(RESET_LEVEL);
      cnt_q         <= '0;
      active_high_q <= high_of(3'(RESET_LEVEL));
      out_q         <= 1'b0;
    end else begin
      inc_s1_q <= increase;
      inc_s2_q <= inc_s1_q;
      inc_p_q  <= inc_s2_q;
      dec_s1_q <= decrease;
      dec_s2_q <= dec_s1_q;
      dec_p_q  <= dec_s2_q;
      level_q  <= level_d;
      cnt_q    <= cnt_d;
      // Duty only changes on the period boundary, using the post-press level.
      if (w_wrap) begin
        active_high_q <= high_of(level_d);
      end
      out_q <= (c_AH_W'(cnt_q) < active_high_q);
    end
  end

  assign out = out_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_5_variation.sv
// ============================================================================
//  Module   : tb_pwm_5_variation
//  Purpose  : Directed self-checking bench for pwm_5_variation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_5_variation;

  logic clk;
  logic rst;
  logic increase;
  logic decrease;
  logic out;

  int n_vec;
  int n_bad;

  pwm_5_variation dut (
    .clk      (clk),
    .out      (out),
    .increase (increase),
    .decrease (decrease),
    .rst      (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    increase = 1'b0;
    decrease = 1'b0;
    tick();
    chk("reset_out_c1", {31'd0, out}, 32'd0);
    tick();
    chk("reset_out_c2", {31'd0, out}, 32'd0);
    rst = 1'b0;
  endtask

  // One full period starting at cnt==0; pattern MSB applies to the first cycle.
  task automatic run_period(input logic [9:0] inc_pat, input logic [9:0] dec_pat,
                            output logic [9:0] got);
    for (int i = 9; i >= 0; i--) begin
      increase = inc_pat[i];
      decrease = dec_pat[i];
      tick();
      got[i] = out;
    end
  endtask

  logic [9:0] w;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    increase = 1'b0;
    decrease = 1'b0;

    // Reset and 50 % steady state
    do_reset();
    run_period(10'b0, 10'b0, w); chk("r50_p1", {22'd0, w}, {22'd0, 10'b1111100000});
    run_period(10'b0, 10'b0, w); chk("r50_p2", {22'd0, w}, {22'd0, 10'b1111100000});

    // decrease held well beyond 4 cycles: one step only, to 3/10
    run_period(10'b0, 10'b1111111111, w); chk("dec_cur", {22'd0, w}, {22'd0, 10'b1111100000});
    run_period(10'b0, 10'b1111111111, w); chk("dec_p1", {22'd0, w}, {22'd0, 10'b1110000000});
    run_period(10'b0, 10'b1111000000, w); chk("dec_p2", {22'd0, w}, {22'd0, 10'b1110000000});
    run_period(10'b0, 10'b0, w);          chk("dec_p3", {22'd0, w}, {22'd0, 10'b1110000000});

    // Three increase presses: 2 -> 3 -> 4 -> 4
    do_reset();
    run_period(10'b1000100010, 10'b0, w); chk("inc3_cur", {22'd0, w}, {22'd0, 10'b1111100000});
    run_period(10'b0, 10'b0, w);          chk("inc3_p1", {22'd0, w}, {22'd0, 10'b1111111110});
    run_period(10'b0, 10'b0, w);          chk("inc3_p2", {22'd0, w}, {22'd0, 10'b1111111110});

    // Both raised together for 6 cycles: no change
    do_reset();
    run_period(10'b1111110000, 10'b1111110000, w); chk("both_cur", {22'd0, w}, {22'd0, 10'b1111100000});
    run_period(10'b0, 10'b0, w);                   chk("both_p1", {22'd0, w}, {22'd0, 10'b1111100000});

    // Press landing at cnt=3: old high time kept, new from next period
    do_reset();
    run_period(10'b0001100000, 10'b0, w); chk("mid_cur", {22'd0, w}, {22'd0, 10'b1111100000});
    run_period(10'b0, 10'b0, w);          chk("mid_p1", {22'd0, w}, {22'd0, 10'b1111111000});
    run_period(10'b0, 10'b0, w);          chk("mid_p2", {22'd0, w}, {22'd0, 10'b1111111000});

    // Level update on the wrap edge applies to the very next period
    do_reset();
    run_period(10'b0000000110, 10'b0, w); chk("wrap_cur", {22'd0, w}, {22'd0, 10'b1111100000});
    run_period(10'b0, 10'b0, w);          chk("wrap_p1", {22'd0, w}, {22'd0, 10'b1111111000});

    // Five decrease presses saturate at 1/10, then reset at cnt=6
    do_reset();
    run_period(10'b0, 10'b1010101010, w); chk("dec5_cur", {22'd0, w}, {22'd0, 10'b1111100000});
    run_period(10'b0, 10'b0, w);          chk("dec5_p1", {22'd0, w}, {22'd0, 10'b1000000000});
    w = '0;
    for (int i = 0; i < 6; i++) begin
      increase = (i == 5);
      tick();
      w[9-i] = out;
    end
    chk("dec5_pre_rst", {22'd0, w}, {22'd0, 10'b1000000000});
    // The increase sampled just before reset must be discarded
    increase = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_out", {31'd0, out}, 32'd0);
    rst = 1'b0;
    run_period(10'b0, 10'b0, w); chk("midrst_p1", {22'd0, w}, {22'd0, 10'b1111100000});
    run_period(10'b0, 10'b0, w); chk("midrst_p2", {22'd0, w}, {22'd0, 10'b1111100000});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
